// File: rtl/qos_queue_pkg.sv
// Shared definitions for the QoS queue slot pointer logic: slot geometry,
// write-FSM state encoding and the inner pointer type.
package qos_queue_pkg;

  localparam int SLOT_AW   = 8;
  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  typedef logic [SLOT_AW-1:0] slot_ptr_t;

endpackage

// File: rtl/qpc_slot_ptr.sv
// Per-slot pointer storage: write inner pointer, read inner pointer and the
// committed packet length (index of the packet's last word).
module qpc_slot_ptr #(
  parameter int SLOT_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrInc_i,
  input  logic               wrCommit_i,
  input  logic               rdInc_i,
  input  logic               rdClear_i,
  output logic [SLOT_AW-1:0] wpInner_o,
  output logic [SLOT_AW-1:0] rpInner_o,
  output logic [SLOT_AW-1:0] len_o
);

  logic [SLOT_AW-1:0] wpInner_q, wpInner_d;
  logic [SLOT_AW-1:0] rpInner_q, rpInner_d;
  logic [SLOT_AW-1:0] len_q, len_d;

  // Commit latches the current write index as the packet length and rewinds the slot.
  always_comb begin
    wpInner_d = wpInner_q;
    rpInner_d = rpInner_q;
    len_d     = len_q;
    if (wrCommit_i) begin
      len_d     = wpInner_q;
      wpInner_d = '0;
    end else if (wrInc_i) begin
      wpInner_d = wpInner_q + 1'b1;
    end
    if (rdClear_i) begin
      rpInner_d = '0;
    end else if (rdInc_i) begin
      rpInner_d = rpInner_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wpInner_q <= '0;
      rpInner_q <= '0;
      len_q     <= '0;
    end else begin
      wpInner_q <= wpInner_d;
      rpInner_q <= rpInner_d;
      len_q     <= len_d;
    end
  end

  assign wpInner_o = wpInner_q;
  assign rpInner_o = rpInner_q;
  assign len_o     = len_q;

endmodule

// File: rtl/queue_slot_pointer_ctrl.sv
// Write/read pointer control for one QoS queue split into four one-packet slots.
// Define QPC_DROP_CNT_EN to add the saturating drop_cnt output.
module queue_slot_pointer_ctrl #(
  parameter int SLOT_AW   = qos_queue_pkg::SLOT_AW,
  parameter int NUM_SLOTS = qos_queue_pkg::NUM_SLOTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic                 wr_last,
  output logic                 wr_accept,
  input  logic                 rd_req,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic [1:0]           wp_outer,
  output logic [1:0]           rp_outer,
  output logic [SLOT_AW-1:0]   wp_inner_0,
  output logic [SLOT_AW-1:0]   wp_inner_1,
  output logic [SLOT_AW-1:0]   wp_inner_2,
  output logic [SLOT_AW-1:0]   wp_inner_3,
  output logic [SLOT_AW-1:0]   rp_inner_0,
  output logic [SLOT_AW-1:0]   rp_inner_1,
  output logic [SLOT_AW-1:0]   rp_inner_2,
  output logic [SLOT_AW-1:0]   rp_inner_3,
  output logic [NUM_SLOTS-1:0] wp_inner_in_en,
  output logic [NUM_SLOTS-1:0] rp_inner_out_en,
  output logic [2:0]           pkt_count,
  output logic                 full,
  output logic                 ovf_err
`ifdef QPC_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  import qos_queue_pkg::*;

  wr_state_e          state_q, state_d;
  logic [1:0]         wpOuter_q, wpOuter_d;
  logic [1:0]         rpOuter_q, rpOuter_d;
  logic [2:0]         pktCount_q, pktCount_d;
  logic               ovfErr_q, ovfErr_d;

  logic [SLOT_AW-1:0] wpInner [NUM_SLOTS];
  logic [SLOT_AW-1:0] rpInner [NUM_SLOTS];
  logic [SLOT_AW-1:0] lenArr  [NUM_SLOTS];

  logic fullFlag, rdValid, wrAtMax;
  logic wrAccept, wrCommit, ovfHit, dropStart;
  logic rdFire, rdLastHit, rdDone;

  assign fullFlag  = (pktCount_q == 3'(NUM_SLOTS));
  assign rdValid   = (pktCount_q != 3'd0);
  assign wrAtMax   = &wpInner[wpOuter_q];
  assign rdLastHit = (rpInner[rpOuter_q] == lenArr[rpOuter_q]);
  assign rdFire    = rd_req && rdValid;
  assign rdDone    = rdFire && rdLastHit;

  // A non-last word at the top of the slot is written as a forced last word;
  // the packet tail is then swallowed in W_DROP.
  always_comb begin
    state_d   = state_q;
    wrAccept  = 1'b0;
    wrCommit  = 1'b0;
    ovfHit    = 1'b0;
    dropStart = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (wr_valid) begin
          if (fullFlag) begin
            dropStart = 1'b1;
            if (!wr_last) state_d = W_DROP;
          end else begin
            wrAccept = 1'b1;
            if (wr_last) begin
              wrCommit = 1'b1;
            end else if (wrAtMax) begin
              wrCommit = 1'b1;
              ovfHit   = 1'b1;
              state_d  = W_DROP;
            end else begin
              state_d = W_FILL;
            end
          end
        end
      end
      W_FILL: begin
        if (wr_valid) begin
          wrAccept = 1'b1;
          if (wr_last) begin
            wrCommit = 1'b1;
            state_d  = W_IDLE;
          end else if (wrAtMax) begin
            wrCommit = 1'b1;
            ovfHit   = 1'b1;
            state_d  = W_DROP;
          end
        end
      end
      W_DROP: begin
        if (wr_valid && wr_last) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wpOuter_d  = wpOuter_q + 2'(wrCommit);
    rpOuter_d  = rpOuter_q + 2'(rdDone);
    ovfErr_d   = ovfErr_q | ovfHit;
    pktCount_d = pktCount_q;
    case ({wrCommit, rdDone})
      2'b10:   pktCount_d = pktCount_q + 3'd1;
      2'b01:   pktCount_d = pktCount_q - 3'd1;
      default: pktCount_d = pktCount_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= W_IDLE;
      wpOuter_q  <= '0;
      rpOuter_q  <= '0;
      pktCount_q <= '0;
      ovfErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wpOuter_q  <= wpOuter_d;
      rpOuter_q  <= rpOuter_d;
      pktCount_q <= pktCount_d;
      ovfErr_q   <= ovfErr_d;
    end
  end

  // Write owns the slot at wpOuter, read owns the slot at rpOuter; they never coincide while active.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : gSlot
    logic wrSel, rdSel;
    assign wrSel              = (wpOuter_q == 2'(i));
    assign rdSel              = (rpOuter_q == 2'(i));
    assign wp_inner_in_en[i]  = wrAccept && wrSel;
    assign rp_inner_out_en[i] = rdFire && rdSel;

    qpc_slot_ptr #(.SLOT_AW(SLOT_AW)) uSlot (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrInc_i    (wrAccept && !wrCommit && wrSel),
      .wrCommit_i (wrCommit && wrSel),
      .rdInc_i    (rdFire && !rdLastHit && rdSel),
      .rdClear_i  (rdDone && rdSel),
      .wpInner_o  (wpInner[i]),
      .rpInner_o  (rpInner[i]),
      .len_o      (lenArr[i])
    );
  end

`ifdef QPC_DROP_CNT_EN
  logic [15:0] dropCnt_q, dropCnt_d;

  // Counted once per packet, on the first word refused because the queue is full.
  assign dropCnt_d = (dropStart && dropCnt_q != 16'hFFFF) ? dropCnt_q + 16'd1 : dropCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dropCnt_q <= '0;
    else        dropCnt_q <= dropCnt_d;
  end

  assign drop_cnt = dropCnt_q;
`else
  logic unusedDrop;
  assign unusedDrop = dropStart;
`endif

  assign wr_accept  = wrAccept;
  assign rd_valid   = rdValid;
  assign rd_last    = rdValid && rdLastHit;
  assign wp_outer   = wpOuter_q;
  assign rp_outer   = rpOuter_q;
  assign pkt_count  = pktCount_q;
  assign full       = fullFlag;
  assign ovf_err    = ovfErr_q;
  assign wp_inner_0 = wpInner[0];
  assign wp_inner_1 = wpInner[1];
  assign wp_inner_2 = wpInner[2];
  assign wp_inner_3 = wpInner[3];
  assign rp_inner_0 = rpInner[0];
  assign rp_inner_1 = rpInner[1];
  assign rp_inner_2 = rpInner[2];
  assign rp_inner_3 = rpInner[3];

endmodule

// File: tb/tb_queue_slot_pointer_ctrl.sv
// Directed bench for queue_slot_pointer_ctrl; inputs change on the falling edge
// and outputs are sampled 1 time unit later.
module tb_queue_slot_pointer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, wr_valid, wr_last, rd_req;
  logic       wr_accept, rd_valid, rd_last, full, ovf_err;
  logic [1:0] wp_outer, rp_outer;
  logic [7:0] wp_inner_0, wp_inner_1, wp_inner_2, wp_inner_3;
  logic [7:0] rp_inner_0, rp_inner_1, rp_inner_2, rp_inner_3;
  logic [3:0] wp_inner_in_en, rp_inner_out_en;
  logic [2:0] pkt_count;
`ifdef QPC_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  logic [7:0] wpIn [4];
  logic [7:0] rpIn [4];
  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clk = ~clk;

  assign wpIn[0] = wp_inner_0;
  assign wpIn[1] = wp_inner_1;
  assign wpIn[2] = wp_inner_2;
  assign wpIn[3] = wp_inner_3;
  assign rpIn[0] = rp_inner_0;
  assign rpIn[1] = rp_inner_1;
  assign rpIn[2] = rp_inner_2;
  assign rpIn[3] = rp_inner_3;

  queue_slot_pointer_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_last         (wr_last),
    .wr_accept       (wr_accept),
    .rd_req          (rd_req),
    .rd_valid        (rd_valid),
    .rd_last         (rd_last),
    .wp_outer        (wp_outer),
    .rp_outer        (rp_outer),
    .wp_inner_0      (wp_inner_0),
    .wp_inner_1      (wp_inner_1),
    .wp_inner_2      (wp_inner_2),
    .wp_inner_3      (wp_inner_3),
    .rp_inner_0      (rp_inner_0),
    .rp_inner_1      (rp_inner_1),
    .rp_inner_2      (rp_inner_2),
    .rp_inner_3      (rp_inner_3),
    .wp_inner_in_en  (wp_inner_in_en),
    .rp_inner_out_en (rp_inner_out_en),
    .pkt_count       (pkt_count),
    .full            (full),
    .ovf_err         (ovf_err)
`ifdef QPC_DROP_CNT_EN
    ,
    .drop_cnt        (drop_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic l, input logic r);
    @(negedge clk);
    wr_valid = v;
    wr_last  = l;
    rd_req   = r;
    #1;
  endtask

  initial begin
    int acc;
    int lastSeen;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_req   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_wp_outer", wp_outer, 0);
    checkOutput("rst_rp_outer", rp_outer, 0);
    checkOutput("rst_pkt_count", pkt_count, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_last", rd_last, 0);
    checkOutput("rst_ovf_err", ovf_err, 0);
    checkOutput("rst_wr_accept", wr_accept, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three 4-word packets into slots 0..2
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 4; w++) begin
        applyStimulus(1'b1, w == 3, 1'b0);
        checkOutput("fill_accept", wr_accept, 1);
        checkOutput("fill_wen", wp_inner_in_en, 32'(4'b0001 << p));
        checkOutput("fill_wp_inner", wpIn[p], w);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("three_pkt_count", pkt_count, 3);
    checkOutput("three_wp_outer", wp_outer, 3);
    checkOutput("three_wp_inner0", wpIn[0], 0);
    checkOutput("three_rd_valid", rd_valid, 1);

    // Fourth packet fills the queue, fifth is dropped whole
    for (int w = 0; w < 4; w++) applyStimulus(1'b1, w == 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("four_full", full, 1);
    checkOutput("four_pkt_count", pkt_count, 4);
    checkOutput("four_wp_outer", wp_outer, 0);
    for (int w = 0; w < 5; w++) begin
      applyStimulus(1'b1, w == 4, 1'b0);
      checkOutput("drop_accept", wr_accept, 0);
      checkOutput("drop_wen", wp_inner_in_en, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drop_wp_outer", wp_outer, 0);
    checkOutput("drop_pkt_count", pkt_count, 4);
    checkOutput("drop_wp_inner0", wpIn[0], 0);
    checkOutput("drop_ovf", ovf_err, 0);
`ifdef QPC_DROP_CNT_EN
    checkOutput("drop_cnt_one", drop_cnt, 1);
`endif

    // Drain all four 4-word packets; rd_last only on the 4th word of each
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("drain_rd_last", rd_last, k == 3);
        checkOutput("drain_ren", rp_inner_out_en, 32'(4'b0001 << s));
        checkOutput("drain_rp_inner", rpIn[s], k);
      end
      if (s == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("drain1_rp_outer", rp_outer, 1);
        checkOutput("drain1_rp_inner0", rpIn[0], 0);
        checkOutput("drain1_pkt_count", pkt_count, 3);
        checkOutput("drain1_full", full, 0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("empty_pkt_count", pkt_count, 0);
    checkOutput("empty_rd_valid", rd_valid, 0);
    checkOutput("empty_rp_outer", rp_outer, 0);

    // 300-word packet: 256 accepted, remainder dropped, ovf_err sticks
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, i == 299, 1'b0);
      acc += int'(wr_accept);
      if (i == 255) checkOutput("ovf_word256_accept", wr_accept, 1);
      if (i == 256) checkOutput("ovf_word257_accept", wr_accept, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovf_accept_total", acc, 256);
    checkOutput("ovf_err", ovf_err, 1);
    checkOutput("ovf_pkt_count", pkt_count, 1);
    checkOutput("ovf_wp_outer", wp_outer, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("after_ovf_wen", wp_inner_in_en, 32'h2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_ovf_pkt_count", pkt_count, 2);
    checkOutput("after_ovf_wp_outer", wp_outer, 2);

    // Read the 256-word packet; its last read coincides with a 1-word commit
    lastSeen = 0;
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      lastSeen += int'(rd_last);
    end
    checkOutput("long_early_last", lastSeen, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("sim_rp_inner0", rpIn[0], 255);
    checkOutput("sim_rd_last", rd_last, 1);
    checkOutput("sim_accept", wr_accept, 1);
    checkOutput("sim_wen", wp_inner_in_en, 32'h4);
    checkOutput("sim_ren", rp_inner_out_en, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sim_pkt_count", pkt_count, 2);
    checkOutput("sim_wp_outer", wp_outer, 3);
    checkOutput("sim_rp_outer", rp_outer, 1);
    checkOutput("sim_rp_inner0_clr", rpIn[0], 0);

    // Drain slot 1 (2 words) and slot 2 (1 word), then reset mid-packet
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tail_rd_last", rd_last, k != 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    #1;
    checkOutput("midrst_wp_inner3", wpIn[3], 0);
    checkOutput("midrst_wp_outer", wp_outer, 0);
    checkOutput("midrst_rp_outer", rp_outer, 0);
    checkOutput("midrst_ovf", ovf_err, 0);
`ifdef QPC_DROP_CNT_EN
    checkOutput("midrst_drop_cnt", drop_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Five write/read rounds of 3-word packets wrap the ring to slot 1
    for (int r = 0; r < 5; r++) begin
      for (int w = 0; w < 3; w++) begin
        applyStimulus(1'b1, w == 2, 1'b0);
        checkOutput("ring_wen", wp_inner_in_en, 32'(4'b0001 << (r % 4)));
      end
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ring_rd_last", rd_last, k == 2);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ring_wp_outer", wp_outer, 1);
    checkOutput("ring_rp_outer", rp_outer, 1);
    checkOutput("ring_pkt_count", pkt_count, 0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_rd_ren", rp_inner_out_en, 0);
    checkOutput("idle_rd_last", rd_last, 0);
    checkOutput("idle_rd_valid", rd_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_rp_outer", rp_outer, 1);
    checkOutput("idle_rp_inner1", rpIn[1], 0);
    checkOutput("idle_wp_outer", wp_outer, 1);
    checkOutput("idle_pkt_count", pkt_count, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
